// File: rtl/imm_encoder_loader.sv
// Program loader: scatters a 32-bit immediate into the I/S/B/U/J field positions
// of a base instruction word and streams the results into IMEM from address 0.
module imm_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        ImmSrc,
    input  logic [31:0]       BaseInstr,
    input  logic [31:0]       Imm,
    input  logic              Last,
    output logic              ImemWE,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [31:0]       ImemWD,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [1:0]        ErrCode,
    output logic [ADDR_W:0]   WordCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WC_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // The base word's own immediate-field bits are dropped by construction.
    function automatic logic [31:0] encode_instr(input logic [2:0]  src,
                                                 input logic [31:0] base,
                                                 input logic [31:0] imm);
        logic [31:0] res;
        case (src)
            3'd0:    res = {imm[11:0], base[19:0]};
            3'd1:    res = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            3'd2:    res = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            3'd3:    res = {imm[31:12], base[11:0]};
            3'd4:    res = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            default: res = base;
        endcase
        return res;
    endfunction

    function automatic logic range_bad(input logic [2:0]  src,
                                       input logic [31:0] imm);
        logic bad;
        case (src)
            3'd0, 3'd1: bad = !((&imm[31:11]) | ~(|imm[31:11]));
            3'd2:       bad = !((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
            3'd3:       bad = |imm[11:0];
            3'd4:       bad = !((&imm[31:20]) | ~(|imm[31:20])) | imm[0];
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              w_ready_nxt;
    logic [1:0]        r_err_code;
    logic [1:0]        w_code_nxt;
    logic              w_write_go;
    logic              w_accept;
    logic              w_illegal;
    logic              w_range_err;
    logic              w_at_top;
    logic              r_we;
    logic [31:0]       r_wd;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_wcount;
    logic              r_last_pend;
    logic              r_ovf_pend;

    assign w_accept    = InValid & r_in_ready;
    assign w_illegal   = (ImmSrc > 3'd4);
    assign w_range_err = range_bad(ImmSrc, Imm);
    assign w_at_top    = (r_wptr == ADDR_TOP);

    // Next-state, error code and write-enable decision.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_err_code;
        w_write_go  = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_RUN: begin
                if (r_last_pend) begin
                    w_state_nxt = S_DONE;
                end else if (r_ovf_pend) begin
                    w_state_nxt = S_ERR;
                    w_code_nxt  = 2'b11;
                end else if (w_accept) begin
                    if (w_illegal) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = 2'b10;
                    end else if (w_range_err) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = 2'b01;
                    end else begin
                        w_write_go  = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
        if (Start) begin
            w_state_nxt = S_RUN;
            w_code_nxt  = 2'b00;
            w_write_go  = 1'b0;
        end else begin
            w_write_go  = w_write_go;
        end
        // Ready drops for the write cycle that ends a session (Last or top address).
        w_ready_nxt = (w_state_nxt == S_RUN) && !(w_write_go && (Last || w_at_top));
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_ready_nxt;
            r_err_code <= w_code_nxt;
        end
    end

    // Write port, address pointer and word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_wd        <= 32'h0000_0000;
            r_waddr     <= {ADDR_W{1'b0}};
            r_wptr      <= {ADDR_W{1'b0}};
            r_wcount    <= {(ADDR_W+1){1'b0}};
            r_last_pend <= 1'b0;
            r_ovf_pend  <= 1'b0;
        end else begin
            r_we        <= w_write_go;
            r_last_pend <= w_write_go & Last;
            r_ovf_pend  <= w_write_go & ~Last & w_at_top;
            if (Start) begin
                r_waddr  <= {ADDR_W{1'b0}};
                r_wptr   <= {ADDR_W{1'b0}};
                r_wcount <= {(ADDR_W+1){1'b0}};
            end else begin
                if (w_write_go) begin
                    r_wd    <= encode_instr(ImmSrc, BaseInstr, Imm);
                    r_waddr <= r_wptr;
                    r_wptr  <= w_at_top ? r_wptr : (r_wptr + ADDR_ONE);
                end else begin
                    r_wptr  <= r_wptr;
                end
                if (r_we && (r_wcount != WC_MAX)) begin
                    r_wcount <= r_wcount + WC_ONE;
                end else begin
                    r_wcount <= r_wcount;
                end
            end
        end
    end

    assign InReady   = r_in_ready;
    assign ImemWE    = r_we;
    assign ImemAddr  = r_waddr;
    assign ImemWD    = r_wd;
    assign Busy      = (r_state == S_RUN);
    assign Done      = (r_state == S_DONE);
    assign Error     = (r_state == S_ERR);
    assign ErrCode   = r_err_code;
    assign WordCount = r_wcount;

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Bench for imm_encoder_loader: directed vector table, hand-written sequences and
// random sessions checked against a value-level encoding model.
module tb_imm_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        InValid;
    logic        Last;
    logic [2:0]  ImmSrc;
    logic [31:0] BaseInstr;
    logic [31:0] Imm;

    logic        InReady, ImemWE, Busy, Done, Error;
    logic [7:0]  ImemAddr;
    logic [31:0] ImemWD;
    logic [1:0]  ErrCode;
    logic [8:0]  WordCount;

    logic        s_InReady, s_ImemWE, s_Busy, s_Done, s_Error;
    logic [1:0]  s_ImemAddr;
    logic [31:0] s_ImemWD;
    logic [1:0]  s_ErrCode;
    logic [2:0]  s_WordCount;

    int n_checks = 0;
    int n_errors = 0;

    imm_encoder_loader #(.ADDR_W(8)) u_dut (
        .clk(clk), .reset(reset), .Start(Start), .InValid(InValid), .InReady(InReady),
        .ImmSrc(ImmSrc), .BaseInstr(BaseInstr), .Imm(Imm), .Last(Last),
        .ImemWE(ImemWE), .ImemAddr(ImemAddr), .ImemWD(ImemWD), .Busy(Busy),
        .Done(Done), .Error(Error), .ErrCode(ErrCode), .WordCount(WordCount));

    imm_encoder_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .reset(reset), .Start(Start), .InValid(InValid), .InReady(s_InReady),
        .ImmSrc(ImmSrc), .BaseInstr(BaseInstr), .Imm(Imm), .Last(Last),
        .ImemWE(s_ImemWE), .ImemAddr(s_ImemAddr), .ImemWD(s_ImemWD), .Busy(s_Busy),
        .Done(s_Done), .Error(s_Error), .ErrCode(s_ErrCode), .WordCount(s_WordCount));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] wd;
        logic [1:0]  code;
    } vec_t;

    vec_t        vecs [0:14];
    logic [2:0]  b_src  [0:7];
    logic [31:0] b_base [0:7];
    logic [31:0] b_imm  [0:7];
    logic [31:0] b_exp  [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed-value range rules and shift/mask field placement.
    function automatic void ref_encode(input logic [2:0] src, input logic [31:0] base,
                                       input logic [31:0] imm, output logic [31:0] wd,
                                       output logic [1:0] code);
        int s;
        s    = $signed(imm);
        code = 2'd0;
        wd   = 32'd0;
        case (src)
            3'd0: begin
                if (s < -2048 || s > 2047) code = 2'd1;
                wd = (base & 32'h000F_FFFF) | (imm << 20);
            end
            3'd1: begin
                if (s < -2048 || s > 2047) code = 2'd1;
                wd = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd2: begin
                if (s < -4096 || s > 4095 || (imm % 32'd2) != 32'd0) code = 2'd1;
                wd = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                   | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7);
            end
            3'd3: begin
                if ((imm % 32'd4096) != 32'd0) code = 2'd1;
                wd = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
            end
            3'd4: begin
                if (s < -(1 << 20) || s >= (1 << 20) || (imm % 32'd2) != 32'd0) code = 2'd1;
                wd = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                   | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                   | (((imm >> 12) & 32'hFF) << 12);
            end
            default: code = 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = $urandom;
            1:       t = 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       t = $urandom & 32'hFFFF_F000;
            default: t = 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
        endcase
        return t;
    endfunction

    task automatic start_session();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("start_busy", {31'd0, Busy}, 32'd1);
        check("start_done_clr", {31'd0, Done}, 32'd0);
        check("start_err_clr", {31'd0, Error}, 32'd0);
        check("start_code_clr", {30'd0, ErrCode}, 32'd0);
        check("start_wcount", {23'd0, WordCount}, 32'd0);
        check("start_ready", {31'd0, InReady}, 32'd1);
    endtask

    task automatic single(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm,
                          input logic [31:0] exp_wd, input logic [1:0] exp_code);
        start_session();
        InValid = 1'b1; ImmSrc = src; BaseInstr = base; Imm = imm; Last = 1'b1;
        tick();
        InValid = 1'b0; Last = 1'b0;
        if (exp_code == 2'd0) begin
            check("one_we", {31'd0, ImemWE}, 32'd1);
            check("one_addr", {24'd0, ImemAddr}, 32'd0);
            check("one_wd", ImemWD, exp_wd);
            check("one_ready_after_last", {31'd0, InReady}, 32'd0);
            tick();
            check("one_we_single", {31'd0, ImemWE}, 32'd0);
            check("one_done", {31'd0, Done}, 32'd1);
            check("one_wcount", {23'd0, WordCount}, 32'd1);
            check("one_busy", {31'd0, Busy}, 32'd0);
        end else begin
            check("err_no_we", {31'd0, ImemWE}, 32'd0);
            check("err_flag", {31'd0, Error}, 32'd1);
            check("err_code", {30'd0, ErrCode}, {30'd0, exp_code});
            tick();
            check("err_sticky", {31'd0, Error}, 32'd1);
            check("err_wcount", {23'd0, WordCount}, 32'd0);
        end
    endtask

    task automatic run_burst(input int n);
        start_session();
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                check("burst_we", {31'd0, ImemWE}, 32'd1);
                check("burst_addr", {24'd0, ImemAddr}, k - 1);
                check("burst_wd", ImemWD, b_exp[k-1]);
            end
            if (k < n) begin
                check("burst_ready", {31'd0, InReady}, 32'd1);
                InValid = 1'b1; ImmSrc = b_src[k]; BaseInstr = b_base[k]; Imm = b_imm[k];
                Last = (k == n - 1);
            end else begin
                check("burst_ready_last", {31'd0, InReady}, 32'd0);
                InValid = 1'b0; Last = 1'b0;
            end
            tick();
        end
        check("burst_done", {31'd0, Done}, 32'd1);
        check("burst_wcount", {23'd0, WordCount}, n);
    endtask

    initial begin
        logic [31:0] wd;
        logic [1:0]  code;
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        int          n;

        reset = 1'b1; Start = 1'b0; InValid = 1'b0; Last = 1'b0;
        ImmSrc = 3'd0; BaseInstr = 32'd0; Imm = 32'd0;
        tick();
        tick();
        check("rst_we", {31'd0, ImemWE}, 32'd0);
        check("rst_ready", {31'd0, InReady}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_wcount", {23'd0, WordCount}, 32'd0);
        reset = 1'b0;

        // IDLE ignores input words.
        InValid = 1'b1; ImmSrc = 3'd0; BaseInstr = 32'h13; Imm = 32'd1; Last = 1'b1;
        tick();
        tick();
        check("idle_no_we", {31'd0, ImemWE}, 32'd0);
        check("idle_not_busy", {31'd0, Busy}, 32'd0);
        InValid = 1'b0; Last = 1'b0;

        vecs[0]  = '{3'd0, 32'h0000_0093, 32'h0000_0005, 32'h0050_0093, 2'd0};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h000F_FFFF, 2'd0};
        vecs[2]  = '{3'd0, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 2'd0};
        vecs[3]  = '{3'd0, 32'h0000_0013, 32'h0000_07FF, 32'h7FF0_0013, 2'd0};
        vecs[4]  = '{3'd0, 32'h0000_0093, 32'h0000_0800, 32'h0000_0000, 2'd1};
        vecs[5]  = '{3'd1, 32'h0000_0023, 32'hFFFF_FFFF, 32'hFE00_0FA3, 2'd0};
        vecs[6]  = '{3'd2, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'd0};
        vecs[7]  = '{3'd2, 32'h0000_0063, 32'h0000_0006, 32'h0000_0363, 2'd0};
        vecs[8]  = '{3'd2, 32'h0000_0063, 32'h0000_0007, 32'h0000_0000, 2'd1};
        vecs[9]  = '{3'd3, 32'h0000_00B7, 32'h1234_5000, 32'h1234_50B7, 2'd0};
        vecs[10] = '{3'd3, 32'h0000_00B7, 32'h1234_5001, 32'h0000_0000, 2'd1};
        vecs[11] = '{3'd4, 32'h0000_00EF, 32'h0000_0008, 32'h0080_00EF, 2'd0};
        vecs[12] = '{3'd4, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 2'd0};
        vecs[13] = '{3'd4, 32'h0000_006F, 32'h0010_0000, 32'h0000_0000, 2'd1};
        vecs[14] = '{3'd5, 32'h0000_0013, 32'hFFFF_0001, 32'h0000_0000, 2'd2};
        for (int i = 0; i <= 14; i++) begin
            single(vecs[i].src, vecs[i].base, vecs[i].imm, vecs[i].wd, vecs[i].code);
        end

        // Back-to-back B, J, U session.
        b_src[0] = 3'd2; b_base[0] = 32'h63; b_imm[0] = 32'hFFFF_FFFC; b_exp[0] = 32'hFE00_0EE3;
        b_src[1] = 3'd4; b_base[1] = 32'hEF; b_imm[1] = 32'h0000_0008; b_exp[1] = 32'h0080_00EF;
        b_src[2] = 3'd3; b_base[2] = 32'hB7; b_imm[2] = 32'h1234_5000; b_exp[2] = 32'h1234_50B7;
        run_burst(3);

        // Overflow on the 4-word instance, with a fifth word offered and ignored.
        start_session();
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                check("ovf_we", {31'd0, s_ImemWE}, 32'd1);
                check("ovf_addr", {30'd0, s_ImemAddr}, k - 1);
            end
            check("ovf_ready", {31'd0, s_InReady}, (k < 4) ? 32'd1 : 32'd0);
            InValid = 1'b1; ImmSrc = 3'd0; BaseInstr = 32'h13; Imm = k; Last = 1'b0;
            tick();
        end
        InValid = 1'b0;
        check("ovf_no_extra_we", {31'd0, s_ImemWE}, 32'd0);
        check("ovf_error", {31'd0, s_Error}, 32'd1);
        check("ovf_code", {30'd0, s_ErrCode}, 32'd3);
        check("ovf_ready_low", {31'd0, s_InReady}, 32'd0);
        check("ovf_wcount", {29'd0, s_WordCount}, 32'd4);
        check("ovf_no_wrap", {30'd0, s_ImemAddr}, 32'd3);

        // Reset while a write is on the port.
        start_session();
        InValid = 1'b1; ImmSrc = 3'd0; BaseInstr = 32'h13; Imm = 32'd1; Last = 1'b0;
        tick();
        Imm = 32'd2;
        tick();
        InValid = 1'b0;
        check("pre_rst_we", {31'd0, ImemWE}, 32'd1);
        check("pre_rst_addr", {24'd0, ImemAddr}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_we", {31'd0, ImemWE}, 32'd0);
        check("async_rst_addr", {24'd0, ImemAddr}, 32'd0);
        check("async_rst_wd", ImemWD, 32'd0);
        check("async_rst_busy", {31'd0, Busy}, 32'd0);
        check("async_rst_ready", {31'd0, InReady}, 32'd0);
        check("async_rst_wcount", {23'd0, WordCount}, 32'd0);
        tick();
        check("rst_hold_we", {31'd0, ImemWE}, 32'd0);
        reset = 1'b0;
        tick();
        single(3'd0, 32'h0000_0093, 32'd5, 32'h0050_0093, 2'd0);

        // Random single-word sessions, legal and illegal.
        for (int i = 0; i < 120; i++) begin
            n    = $urandom_range(0, 15);
            src  = (n < 13) ? 3'(n % 5) : 3'(5 + n % 3);
            base = $urandom;
            imm  = gen_imm();
            ref_encode(src, base, imm, wd, code);
            single(src, base, imm, wd, code);
        end

        // Random legal bursts.
        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                code = 2'd1;
                for (int t = 0; t < 16 && code != 2'd0; t++) begin
                    src  = 3'($urandom_range(0, 4));
                    base = $urandom;
                    imm  = gen_imm();
                    ref_encode(src, base, imm, wd, code);
                end
                if (code != 2'd0) begin
                    src = 3'd3; imm = 32'd0;
                    ref_encode(src, base, imm, wd, code);
                end
                b_src[k] = src; b_base[k] = base; b_imm[k] = imm; b_exp[k] = wd;
            end
            run_burst(n);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
